// File: rtl/receptor_adc_if.sv
`default_nettype none
// ============================================================================
// Module      : receptor_adc_if
// Description : Signal bundle between the SPI ADC pins, the upstream enable
//               stage and the downstream consumer of the 12-bit result.
//               master = side that drives hab/sclk/sdata,
//               slave  = the deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface receptor_adc_if #(
  parameter int DATA_W = 12
);
  logic              hab;
  logic              sclk;
  logic              sdata;
  logic [DATA_W-1:0] dato;
  logic              listo;
  logic              ocupado;
  logic              err;

  modport master (
    output hab,
    output sclk,
    output sdata,
    input  dato,
    input  listo,
    input  ocupado,
    input  err
  );

  modport slave (
    input  hab,
    input  sclk,
    input  sdata,
    output dato,
    output listo,
    output ocupado,
    output err
  );
endinterface
`default_nettype wire

// File: rtl/receptor_adc.sv
`default_nettype none
// ============================================================================
// Module      : receptor_adc
// Description : SPI ADC serial deserializer. Armed by a one-cycle hab pulse,
//               it samples sdata on each synchronized rising edge of sclk and,
//               after NBITS edges, presents the last DATA_W bits on dato with
//               a one-cycle listo strobe. A watchdog aborts stalled frames and
//               raises the sticky err flag.
//               Optional feature macro: ADC_ZERO_CHECK_EN - when defined the
//               leading NBITS-DATA_W bits must be zero, otherwise err is set
//               together with listo.
// Revision    : 1.0 - initial release
// ============================================================================
module receptor_adc #(
  parameter int NBITS   = 16,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  receptor_adc_if.slave  bus
);

  localparam int CNT_W = $clog2(NBITS) + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NBITS);
  // Abort fires on the edge where the watchdog would reach TIMEOUT, so the
  // frame ends exactly TIMEOUT cycles after the last sample.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

`ifdef ADC_ZERO_CHECK_EN
  // Leading bits must be kept so they can be inspected at the end of frame.
  localparam int SHIFT_W = NBITS;
`else
  // Leading bits are never inspected, so they are simply shifted out.
  localparam int SHIFT_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ESPERA   = 2'd1,
    DESPLAZA = 2'd2,
    FIN      = 2'd3
  } state_t;

  logic               sclk_s1_q;
  logic               sclk_s2_q;
  logic               sclk_prev_q;
  logic               sdata_s1_q;
  logic               sdata_s2_q;
  logic               sclk_rise;

  state_t             state_q,   state_d;
  logic [SHIFT_W-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [7:0]         wd_q,      wd_d;
  logic [DATA_W-1:0]  dato_q,    dato_d;
  logic               listo_q,   listo_d;
  logic               ocupado_q, ocupado_d;
  logic               err_q,     err_d;

  logic               lead_bad;
  logic [7:0]         wd_inc;
  logic               edge_window;

  // Two-stage synchronizers plus the edge-detect register; sdata has the same
  // depth so the sampled bit lines up with sclk_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdata_s1_q  <= 1'b0;
      sdata_s2_q  <= 1'b0;
    end else begin
      sclk_s1_q   <= bus.sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdata_s1_q  <= bus.sdata;
      sdata_s2_q  <= sdata_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;

`ifdef ADC_ZERO_CHECK_EN
  assign lead_bad = |shift_q[NBITS-1:DATA_W];
`else
  assign lead_bad = 1'b0;
`endif

  // Saturating increment keeps the watchdog from wrapping for large TIMEOUT.
  assign wd_inc = (wd_q == 8'hFF) ? wd_q : (wd_q + 8'd1);

  // A sample may be taken in ESPERA, or in DESPLAZA until the frame is full.
  assign edge_window = (state_q == ESPERA) ||
                       ((state_q == DESPLAZA) && (cnt_q != CNT_END));

  // Next-state and datapath logic for the frame FSM.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    dato_d    = dato_q;
    listo_d   = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.hab) begin
          state_d = ESPERA;
          shift_d = '0;
          cnt_d   = '0;
          wd_d    = '0;
          err_d   = 1'b0;
        end
      end

      ESPERA, DESPLAZA: begin
        if (!edge_window) begin
          // All NBITS samples are in; hand over to the result stage.
          state_d = FIN;
        end else if (sclk_rise) begin
          // The edge wins over a coincident watchdog expiry.
          shift_d = {shift_q[SHIFT_W-2:0], sdata_s2_q};
          cnt_d   = cnt_q + CNT_W'(1);
          wd_d    = '0;
          state_d = DESPLAZA;
        end else if (wd_q >= WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end

      FIN: begin
        dato_d  = shift_q[DATA_W-1:0];
        listo_d = 1'b1;
        state_d = IDLE;
        if (lead_bad) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ocupado_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      dato_q    <= '0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      dato_q    <= dato_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
      err_q     <= err_d;
    end
  end

  assign bus.dato    = dato_q;
  assign bus.listo   = listo_q;
  assign bus.ocupado = ocupado_q;
  assign bus.err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_receptor_adc.sv
`default_nettype none
// ============================================================================
// Module      : tb_receptor_adc
// Description : Directed bench for receptor_adc with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_receptor_adc;

`ifdef ADC_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct {
    logic [11:0] dato;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   listo_cnt;
  int   last_listo_cyc;
  int   last_raise_cyc;
  logic prev_listo;
  exp_t exp_q[$];

  receptor_adc_if #(.DATA_W(12)) bus ();

  receptor_adc #(
    .NBITS   (16),
    .DATA_W  (12),
    .TIMEOUT (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every listo pops one expected result.
  always @(negedge clk) begin
    if (bus.listo === 1'b1) begin
      exp_t e;
      listo_cnt++;
      last_listo_cyc = cyc;
      check("listo_single", 32'(prev_listo), 32'd0);
      check("ocupado_at_listo", 32'(bus.ocupado), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dato", 32'(bus.dato), 32'(e.dato));
        check("err_at_listo", 32'(bus.err), 32'(e.err));
      end
    end
    prev_listo = bus.listo;
  end

  // Called at a negedge; hab is high for exactly one clock.
  task automatic do_hab();
    bus.hab = 1'b1;
    @(negedge clk);
    bus.hab = 1'b0;
  endtask

  // One sclk period of 10 clk: low half carries the new bit, rise after 5.
  // Returns at the 5th negedge after the rise.
  task automatic send_bit(input logic b, input logic pulse);
    @(negedge clk);
    bus.sclk  = 1'b0;
    bus.sdata = b;
    bus.hab   = pulse;
    @(negedge clk);
    bus.hab   = 1'b0;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    last_raise_cyc = cyc;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int last, input int pulse_bit);
    for (int i = first; i <= last; i++) begin
      send_bit(w[15-i], (i == pulse_bit));
    end
  endtask

  task automatic push_exp(input logic [15:0] w);
    exp_t e;
    e.dato = w[11:0];
    e.err  = ZCHK && (w[15:12] != 4'h0);
    exp_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    n_checks = 0; n_fail = 0; listo_cnt = 0; last_listo_cyc = -1;
    last_raise_cyc = 0; prev_listo = 1'b0; cyc = 0;
    rst = 1'b1;
    bus.hab = 1'b0; bus.sclk = 1'b0; bus.sdata = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dato", 32'(bus.dato), 32'h0);
    check("rst_listo", 32'(bus.listo), 32'd0);
    check("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);

    // Nominal frame 0x0A5C with latency check.
    do_hab();
    check("hab_ocupado_nom", 32'(bus.ocupado), 32'd1);
    push_exp(16'h0A5C);
    send_bits(16'h0A5C, 0, 15, -1);
    @(negedge clk);
    check("listo_latency", 32'(last_listo_cyc), 32'(last_raise_cyc + 5));
    check("err_after_nom", 32'(bus.err), 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back: hab issued during the listo cycle of the first frame.
    do_hab();
    push_exp(16'h0FFF);
    send_bits(16'h0FFF, 0, 15, -1);
    check("b2b_listo_cycle", 32'(bus.listo), 32'd1);
    check("b2b_dato_first", 32'(bus.dato), 32'hFFF);
    do_hab();
    check("b2b_rearm", 32'(bus.ocupado), 32'd1);
    push_exp(16'h0001);
    send_bits(16'h0001, 0, 15, -1);
    repeat (3) @(negedge clk);

    // Busy ignore: extra hab at bit 5.
    do_hab();
    push_exp(16'h0123);
    send_bits(16'h0123, 0, 15, 5);
    repeat (3) @(negedge clk);
    check("busy_dato", 32'(bus.dato), 32'h123);

    // Timeout: sclk stalls after 7 edges.
    do_hab();
    send_bits(16'hFFFF, 0, 5, -1);
    @(negedge clk);
    bus.sclk = 1'b0;
    bus.sdata = 1'b1;
    repeat (5) @(negedge clk);
    bus.sclk = 1'b1;
    c = cyc;
    while (cyc < c + 22) @(negedge clk);
    check("to_err_before", 32'(bus.err), 32'd0);
    check("to_ocupado_before", 32'(bus.ocupado), 32'd1);
    @(negedge clk);
    check("to_err", 32'(bus.err), 32'd1);
    check("to_ocupado", 32'(bus.ocupado), 32'd0);
    check("to_dato_kept", 32'(bus.dato), 32'h123);
    repeat (3) @(negedge clk);

    // Zero-check frame; hab acceptance clears the sticky error.
    do_hab();
    check("err_cleared_by_hab", 32'(bus.err), 32'd0);
    push_exp(16'h8123);
    send_bits(16'h8123, 0, 15, -1);
    repeat (3) @(negedge clk);

    // Reset at bit 9, then the remaining edges arrive without hab.
    do_hab();
    send_bits(16'h0A5C, 0, 8, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_dato", 32'(bus.dato), 32'h0);
    check("midrst_listo", 32'(bus.listo), 32'd0);
    check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    send_bits(16'h0A5C, 9, 15, -1);
    repeat (10) @(negedge clk);
    check("listo_total", 32'(listo_cnt), 32'd5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
